// File: rtl/calc_pkg.sv
// Shared types for the calculator ALU: opcodes, FSM states and opcode width.
package calc_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } calc_alu_state_t;

endpackage

// File: rtl/calc_muldiv_core.sv
// Iterative magnitude multiplier (shift-add) and restoring divider, one step per cycle.
// The divider is only built when CALC_ALU_DIVIDE_EN is defined.
module calc_muldiv_core #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_is_div,
  input  logic [DATA_WIDTH-1:0]     i_operand_a,
  input  logic [DATA_WIDTH-1:0]     i_operand_b,
  output logic                      o_done,
  output logic [2*DATA_WIDTH-1:0]   o_mag
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);

  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*DW-1:0]   acc_q, acc_d;
  logic [2*DW-1:0]   mcand_q, mcand_d;
  logic [DW-1:0]     mplier_q, mplier_d;
  logic [DW-1:0]     mag_a, mag_b;

`ifdef CALC_ALU_DIVIDE_EN
  logic              is_div_q, is_div_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic [DW-1:0]     divisor_q, divisor_d;
  logic [DW:0]       shifted;
`else
  logic              unused_div;
  assign unused_div = i_is_div;
`endif

  // Two's-complement magnitude; -2^(DW-1) maps to 2^(DW-1), which still fits unsigned.
  assign mag_a = i_operand_a[DW-1] ? (~i_operand_a) + {{(DW-1){1'b0}}, 1'b1} : i_operand_a;
  assign mag_b = i_operand_b[DW-1] ? (~i_operand_b) + {{(DW-1){1'b0}}, 1'b1} : i_operand_b;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    o_done   = busy_q && (cnt_q == CW'(DW-1));
`ifdef CALC_ALU_DIVIDE_EN
    is_div_d  = is_div_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    shifted   = {rem_q, quo_q[DW-1]};
`endif
    if (i_start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{DW{1'b0}}, mag_a};
      mplier_d = mag_b;
`ifdef CALC_ALU_DIVIDE_EN
      is_div_d  = i_is_div;
      rem_d     = '0;
      quo_d     = mag_a;
      divisor_d = mag_b;
`endif
    end else if (busy_q) begin
      cnt_d    = cnt_q + CW'(1);
      busy_d   = !o_done;
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
`ifdef CALC_ALU_DIVIDE_EN
      if (shifted >= {1'b0, divisor_q}) begin
        rem_d = shifted[DW-1:0] - divisor_q;
        quo_d = {quo_q[DW-2:0], 1'b1};
      end else begin
        rem_d = shifted[DW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b0};
      end
`endif
    end
    // Presented from the next-state value so the caller can latch it on the final step edge.
`ifdef CALC_ALU_DIVIDE_EN
    o_mag = is_div_q ? {{DW{1'b0}}, quo_d} : acc_d;
`else
    o_mag = acc_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef CALC_ALU_DIVIDE_EN
      is_div_q  <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
`endif
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef CALC_ALU_DIVIDE_EN
      is_div_q  <= is_div_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
`endif
    end
  end

endmodule

// File: rtl/calc_alu.sv
// Signed calculator ALU: add/sub in one cycle, mul/div iterative, magnitude+sign+error result.
// Define CALC_ALU_DIVIDE_EN to build the divider; otherwise DIV reports an error.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_operand_a,
  input  logic [DATA_WIDTH-1:0] i_operand_b,
  input  logic [1:0]            i_op,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_error,
  output logic                  o_result_is_neg,
  output logic                  o_valid,
  input  logic                  i_ready
);
  localparam int DW = DATA_WIDTH;
`ifdef CALC_ALU_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [2*DW-1:0] NEG_LIM = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic [2*DW-1:0] POS_LIM = NEG_LIM - {{(2*DW-1){1'b0}}, 1'b1};

  calc_alu_state_t state_q, state_d;
  alu_op_t         op_q, op_d, in_op;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic            fast_q, fast_d, fast_cmd;
  logic [DW-1:0]   result_q, result_d;
  logic            err_q, err_d, neg_q, neg_d, valid_q, valid_d;

  logic            core_start, core_done;
  logic [2*DW-1:0] core_mag;
  logic [DW:0]     sum, sum_mag;
  logic [2*DW-1:0] res_mag;
  logic            res_neg, force_err, fin_err, fin_neg;
  logic [DW-1:0]   fin_result;

  assign in_op    = alu_op_t'(i_op);
  // Commands that never touch the iterative core finish one edge after accept.
  assign fast_cmd = (in_op == ADD) || (in_op == SUB) ||
                    ((in_op == DIV) && ((i_operand_b == '0) || !DIV_EN));

  calc_muldiv_core #(.DATA_WIDTH(DW)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (core_start),
    .i_is_div    (in_op == DIV),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_done      (core_done),
    .o_mag       (core_mag)
  );

  always_comb begin
    sum       = (op_q == SUB) ? {a_q[DW-1], a_q} - {b_q[DW-1], b_q}
                              : {a_q[DW-1], a_q} + {b_q[DW-1], b_q};
    sum_mag   = sum[DW] ? (~sum) + {{DW{1'b0}}, 1'b1} : sum;
    res_mag   = core_mag;
    res_neg   = a_q[DW-1] ^ b_q[DW-1];
    force_err = 1'b0;
    if (fast_q) begin
      if ((op_q == ADD) || (op_q == SUB)) begin
        res_mag = {{(DW-1){1'b0}}, sum_mag};
        res_neg = sum[DW];
      end else begin
        force_err = 1'b1;
      end
    end
    // 2^(DW-1) is representable only as a negative result.
    fin_err    = force_err || (res_neg ? (res_mag > NEG_LIM) : (res_mag > POS_LIM));
    fin_result = fin_err ? '0 : res_mag[DW-1:0];
    fin_neg    = !fin_err && res_neg && (res_mag != '0);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    fast_d     = fast_q;
    result_d   = result_q;
    err_d      = err_q;
    neg_d      = neg_q;
    valid_d    = valid_q;
    core_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          op_d       = in_op;
          a_d        = i_operand_a;
          b_d        = i_operand_b;
          fast_d     = fast_cmd;
          core_start = !fast_cmd;
          state_d    = COMPUTE;
        end
      end
      COMPUTE: begin
        if (fast_q || core_done) begin
          result_d = fin_result;
          err_d    = fin_err;
          neg_d    = fin_neg;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      fast_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fast_q   <= fast_d;
      result_q <= result_d;
      err_q    <= err_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
    end
  end

  assign o_ready         = (state_q == IDLE);
  assign o_result        = result_q;
  assign o_error         = err_q;
  assign o_result_is_neg = neg_q;
  assign o_valid         = valid_q;

endmodule

// File: tb/tb_calc_alu.sv
// Directed self-checking bench for calc_alu (DATA_WIDTH=16); DIV expectations follow CALC_ALU_DIVIDE_EN.
module tb_calc_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_operand_a, i_operand_b;
  logic [1:0]  i_op;
  logic        i_valid, i_ready;
  logic        o_ready, o_error, o_result_is_neg, o_valid;
  logic [15:0] o_result;

  int tests_run    = 0;
  int tests_failed = 0;

  calc_alu #(.DATA_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_operand_a     (i_operand_a),
    .i_operand_b     (i_operand_b),
    .i_op            (i_op),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .o_result        (o_result),
    .o_error         (o_error),
    .o_result_is_neg (o_result_is_neg),
    .o_valid         (o_valid),
    .i_ready         (i_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command from IDLE and wait (bounded) for o_valid; lat = -1 on timeout.
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         output int lat, output logic [15:0] res,
                         output logic err, output logic neg);
    i_operand_a = a;
    i_operand_b = b;
    i_op        = op;
    i_valid     = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        lat = k;
        break;
      end
    end
    res = o_result;
    err = o_error;
    neg = o_result_is_neg;
    $display("[TB] op=%0d a=%h b=%h -> res=%h err=%b neg=%b lat=%0d", op, a, b, res, err, neg, lat);
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({o_valid, o_error, o_result_is_neg, o_ready} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_flags: valid/err/neg/ready=%b expected 0001",
               {o_valid, o_error, o_result_is_neg, o_ready});
    end
    tests_run++;
    if (o_result !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_result: got %h expected 0000", o_result);
    end
  endtask

  // Shared checker body is inlined per task; this table drives add/sub vectors.
  task automatic test_addsub();
    logic [15:0] va [5] = '{16'h0005, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
    logic [15:0] vb [5] = '{16'hFFF8, 16'hFFFF, 16'h8000, 16'h0000, 16'h0000};
    logic [1:0]  vo [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    logic [15:0] er [5] = '{16'h0003, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
    logic        ee [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        en [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [15:0] res; logic err, neg;
    for (int i = 0; i < 5; i++) begin
      run_cmd(va[i], vb[i], vo[i], lat, res, err, neg);
      tests_run++;
      if ({res, err, neg} !== {er[i], ee[i], en[i]} || lat !== 1) begin
        tests_failed++;
        $display("FAIL addsub_%0d: res=%h err=%b neg=%b lat=%0d expected res=%h err=%b neg=%b lat=1",
                 i, res, err, neg, lat, er[i], ee[i], en[i]);
      end
      handshake();
    end
  endtask

  task automatic test_mul();
    logic [15:0] va [4] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0003};
    logic [15:0] vb [4] = '{16'h0080, 16'h0080, 16'hFFFF, 16'hFFFB};
    logic [15:0] er [4] = '{16'h8000, 16'h0000, 16'h0000, 16'h000F};
    logic        ee [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        en [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat; logic [15:0] res; logic err, neg;
    for (int i = 0; i < 4; i++) begin
      run_cmd(va[i], vb[i], 2'd2, lat, res, err, neg);
      tests_run++;
      if ({res, err, neg} !== {er[i], ee[i], en[i]} || lat !== 16) begin
        tests_failed++;
        $display("FAIL mul_%0d: res=%h err=%b neg=%b lat=%0d expected res=%h err=%b neg=%b lat=16",
                 i, res, err, neg, lat, er[i], ee[i], en[i]);
      end
      handshake();
    end
  endtask

  task automatic test_div();
`ifdef CALC_ALU_DIVIDE_EN
    logic [15:0] va [4] = '{16'hFFF9, 16'h1234, 16'h8000, 16'h0064};
    logic [15:0] vb [4] = '{16'h0002, 16'h0000, 16'hFFFF, 16'hFFF9};
    logic [15:0] er [4] = '{16'h0003, 16'h0000, 16'h0000, 16'h000E};
    logic        ee [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        en [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          el [4] = '{16, 1, 16, 16};
`else
    logic [15:0] va [4] = '{16'h0010, 16'h1234, 16'hFFF9, 16'h8000};
    logic [15:0] vb [4] = '{16'h0002, 16'h0000, 16'h0002, 16'hFFFF};
    logic [15:0] er [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        ee [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic        en [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          el [4] = '{1, 1, 1, 1};
`endif
    int lat; logic [15:0] res; logic err, neg;
    for (int i = 0; i < 4; i++) begin
      run_cmd(va[i], vb[i], 2'd3, lat, res, err, neg);
      tests_run++;
      if ({res, err, neg} !== {er[i], ee[i], en[i]} || lat !== el[i]) begin
        tests_failed++;
        $display("FAIL div_%0d: res=%h err=%b neg=%b lat=%0d expected res=%h err=%b neg=%b lat=%0d",
                 i, res, err, neg, lat, er[i], ee[i], en[i], el[i]);
      end
      handshake();
    end
    // ADD must still work after DIV traffic.
    run_cmd(16'h0010, 16'hFFF0, 2'd0, lat, res, err, neg);
    tests_run++;
    if ({res, err, neg} !== {16'h0000, 1'b0, 1'b0} || lat !== 1) begin
      tests_failed++;
      $display("FAIL div_then_add: res=%h err=%b neg=%b lat=%0d expected res=0000 err=0 neg=0 lat=1",
               res, err, neg, lat);
    end
    handshake();
  endtask

  task automatic test_stall();
    int lat; logic [15:0] res; logic err, neg;
    int bad = 0;
    run_cmd(16'h0001, 16'h0002, 2'd0, lat, res, err, neg);
    for (int i = 0; i < 10; i++) begin
      i_valid     = i[0];
      i_operand_a = 16'(i * 16'h0111);
      i_op        = 2'd1;
      @(posedge clk); #1;
      if (!(o_valid === 1'b1 && o_result === 16'h0003 && o_error === 1'b0 &&
            o_result_is_neg === 1'b0 && o_ready === 1'b0))
        bad++;
    end
    i_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: %0d cycles with changed outputs, expected 0", bad);
    end
    handshake();
    tests_run++;
    if ({o_valid, o_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_release: valid/ready=%b expected 01", {o_valid, o_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({o_valid, o_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_no_accept: valid/ready=%b expected 01", {o_valid, o_ready});
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [15:0] res; logic err, neg;
    int seen = 0;
    i_operand_a = 16'hFF00;
    i_operand_b = 16'h0080;
    i_op        = 2'd2;
    i_valid     = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_valid, o_error, o_result_is_neg, o_ready, o_result} !== {4'b0001, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_mid_mul: valid/err/neg/ready=%b res=%h expected 0001 0000",
               {o_valid, o_error, o_result_is_neg, o_ready}, o_result);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_no_replay: o_valid seen %0d cycles expected 0", seen);
    end
    // Abort while holding a result in DONE.
    run_cmd(16'hFFFF, 16'hFFFE, 2'd0, lat, res, err, neg);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_valid, o_error, o_result_is_neg, o_ready, o_result} !== {4'b0001, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_mid_done: valid/err/neg/ready=%b res=%h expected 0001 0000",
               {o_valid, o_error, o_result_is_neg, o_ready}, o_result);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    run_cmd(16'h0001, 16'h0001, 2'd0, lat, res, err, neg);
    tests_run++;
    if ({res, err, neg} !== {16'h0002, 1'b0, 1'b0} || lat !== 1) begin
      tests_failed++;
      $display("FAIL reset_then_add: res=%h err=%b neg=%b lat=%0d expected res=0002 err=0 neg=0 lat=1",
               res, err, neg, lat);
    end
    handshake();
  endtask

  initial begin
    rst_n       = 1'b0;
    i_operand_a = '0;
    i_operand_b = '0;
    i_op        = 2'd0;
    i_valid     = 1'b0;
    i_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_stall();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
